// File: rtl/clk_pkg.sv
// ============================================================================
// Module   : clk_pkg
// Purpose  : Shared definitions for the clock/reset sequencer. Holds the
//            sequencer state encoding (HOLD, WAIT_LOCK, SETTLE, RUN), the
//            default timing constants and the sequencing counter width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_pkg;

    // Default timing, in clk_33 cycles
    localparam int c_RST_CYCLES_DEF    = 16;
    localparam int c_LOCK_TIMEOUT_DEF  = 4096;
    localparam int c_SETTLE_CYCLES_DEF = 64;
    localparam int c_RETRY_W_DEF       = 4;

    // Sequencer states
    localparam logic [1:0] c_ST_HOLD      = 2'd0;
    localparam logic [1:0] c_ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] c_ST_SETTLE    = 2'd2;
    localparam logic [1:0] c_ST_RUN       = 2'd3;

    // Width of the single shared counter: enough to hold the largest
    // terminal count (max - 1). Never narrower than one bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : Generic two-flop synchroniser for asynchronous inputs, with a
//            synchronous active-high reset to 0.
// Ports    : clk_i - destination clock
//            rst_i - synchronous active-high reset
//            d_i   - asynchronous input  [WIDTH-1:0]
//            q_o   - synchronised output [WIDTH-1:0], 2 cycles latency
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/clk_reset_sequencer.sv
// ============================================================================
// Module   : clk_reset_sequencer
// Purpose  : Pulses the PLL/DCM reset, waits for lock with timeout and retry,
//            requires a continuous lock-stable settle window, then releases
//            the system reset for the generated clock domains. Runs entirely
//            on the free-running board clock.
// Ports    : clk_33      in  - free-running board clock
//            rst         in  - synchronous active-high reset
//            locked      in  - asynchronous lock from the clock controller
//            clk_rst     out - PLL/DCM reset, registered
//            sys_rst     out - system reset, registered, low only in RUN
//            ready       out - registered, high only in RUN
//            retry_count out - saturating timeout-retry count (status build)
//            lock_lost   out - sticky lock loss in RUN (status build)
// Options  : CLK_RESET_SEQ_STATUS_EN adds retry_count / lock_lost
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_reset_sequencer
    import clk_pkg::*;
#(
    parameter int RST_CYCLES    = c_RST_CYCLES_DEF,
    parameter int LOCK_TIMEOUT  = c_LOCK_TIMEOUT_DEF,
    parameter int SETTLE_CYCLES = c_SETTLE_CYCLES_DEF
`ifdef CLK_RESET_SEQ_STATUS_EN
    ,
    parameter int RETRY_W       = c_RETRY_W_DEF
`endif
) (
    input  logic               clk_33,
    input  logic               rst,
    input  logic               locked,
    output logic               clk_rst,
    output logic               sys_rst,
    output logic               ready
`ifdef CLK_RESET_SEQ_STATUS_EN
    ,
    output logic [RETRY_W-1:0] retry_count,
    output logic               lock_lost
`endif
);

    localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);

    localparam logic [CNT_W-1:0] c_RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

    logic             locked_s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_rst_q, sys_rst_q, ready_q;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk_i (clk_33),
        .rst_i (rst),
        .d_i   (locked),
        .q_o   (locked_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_ST_HOLD: begin
                if (cnt_q == c_RST_LAST) state_d = c_ST_WAIT_LOCK;
            end
            c_ST_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (locked_s)                      state_d = c_ST_SETTLE;
                else if (cnt_q == c_TIMEOUT_LAST)  state_d = c_ST_HOLD;
            end
            c_ST_SETTLE: begin
                if (!locked_s)                     state_d = c_ST_WAIT_LOCK;
                else if (cnt_q == c_SETTLE_LAST)   state_d = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (!locked_s) state_d = c_ST_HOLD;
            end
            default: state_d = c_ST_HOLD;
        endcase

        // Every state starts its count from zero. RUN has no terminal
        // count, so the counter is frozen there instead of wrapping.
        if (state_d != state_q)     cnt_d = '0;
        else if (state_q != c_ST_RUN) cnt_d = cnt_q + 1'b1;
    end

    // Outputs are decoded from next-state so they change on the same edge
    // as the state register, with no input-to-output combinational path.
    always_ff @(posedge clk_33) begin
        if (rst) begin
            state_q   <= c_ST_HOLD;
            cnt_q     <= '0;
            clk_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clk_rst_q <= (state_d == c_ST_HOLD);
            sys_rst_q <= (state_d != c_ST_RUN);
            ready_q   <= (state_d == c_ST_RUN);
        end
    end

    assign clk_rst = clk_rst_q;
    assign sys_rst = sys_rst_q;
    assign ready   = ready_q;

`ifdef CLK_RESET_SEQ_STATUS_EN
    logic [RETRY_W-1:0] retry_q;
    logic               lock_lost_q;

    always_ff @(posedge clk_33) begin
        if (rst) begin
            retry_q     <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            if ((state_q == c_ST_WAIT_LOCK) && (state_d == c_ST_HOLD) && (retry_q != '1))
                retry_q <= retry_q + 1'b1;
            if ((state_q == c_ST_RUN) && (state_d == c_ST_HOLD))
                lock_lost_q <= 1'b1;
        end
    end

    assign retry_count = retry_q;
    assign lock_lost   = lock_lost_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clk_reset_sequencer.sv
// ============================================================================
// Module   : tb_clk_reset_sequencer
// Purpose  : Self-checking bench for clk_reset_sequencer. Expected timings
//            are derived arithmetically from the sequencing rules: two-cycle
//            lock synchroniser, one decision edge, registered outputs.
// Options  : CLK_RESET_SEQ_STATUS_EN enables the status checks
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_reset_sequencer;

    localparam int RSTC = 16;
    localparam int TO   = 4096;
    localparam int SET  = 64;
    localparam int RW   = 2;
    localparam int SYNC = 2;
    // Cycles from driving locked until ready rises in a clean acquisition
    localparam int LOCK_TO_READY = SYNC + 1 + SET;
    // Cycles from dropping locked in RUN until sys_rst reasserts
    localparam int DROP_TO_RST   = SYNC + 1;

    logic clk_33 = 1'b0;
    logic rst    = 1'b1;
    logic locked = 1'b0;
    logic clk_rst, sys_rst, ready;
`ifdef CLK_RESET_SEQ_STATUS_EN
    logic [RW-1:0] retry_count;
    logic          lock_lost;
`endif

    int   errors = 0;
    int   checks = 0;
    logic crst_or = 1'b0;

    clk_reset_sequencer #(
        .RST_CYCLES    (RSTC),
        .LOCK_TIMEOUT  (TO),
        .SETTLE_CYCLES (SET)
`ifdef CLK_RESET_SEQ_STATUS_EN
        ,
        .RETRY_W       (RW)
`endif
    ) dut (
        .clk_33      (clk_33),
        .rst         (rst),
        .locked      (locked),
        .clk_rst     (clk_rst),
        .sys_rst     (sys_rst),
        .ready       (ready)
`ifdef CLK_RESET_SEQ_STATUS_EN
        ,
        .retry_count (retry_count),
        .lock_lost   (lock_lost)
`endif
    );

    always #15 clk_33 = ~clk_33;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_33);
        #1;
        crst_or = crst_or | clk_rst;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return clk_rst;
            1:       return sys_rst;
            default: return ready;
        endcase
    endfunction

    // Count cycles while the selected output holds 'val', up to 'bound'.
    task automatic run_len(input int sel, input logic val, input int bound, output int n);
        n = 0;
        while ((sig(sel) === val) && (n < bound)) begin
            tick();
            n++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clk_rst"}, 32'(clk_rst), 32'd1);
        check({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
        check({tag, "_ready"},   32'(ready),   32'd0);
`ifdef CLK_RESET_SEQ_STATUS_EN
        check({tag, "_retry"},   32'(retry_count), 32'd0);
        check({tag, "_lost"},    32'(lock_lost),   32'd0);
`endif
    endtask

    initial begin
        int n, d, k, len, w, exp_retry;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("reset");

        // Release with no lock: HOLD, full timeout, retry HOLD
        rst = 1'b0;
        run_len(0, 1'b1, RSTC + 50, n);
        check("hold_len_first", 32'(n), 32'(RSTC));
        run_len(0, 1'b0, TO + 50, n);
        check("wait_len_timeout", 32'(n), 32'(TO));
        check("sys_rst_during_retry", 32'(sys_rst), 32'd1);
`ifdef CLK_RESET_SEQ_STATUS_EN
        check("retry_after_timeout", 32'(retry_count), 32'd1);
`endif
        run_len(0, 1'b1, RSTC + 50, n);
        check("hold_len_retry", 32'(n), 32'(RSTC));

        // Clean acquisition after a random delay in WAIT_LOCK
        crst_or = 1'b0;
        d = $urandom_range(20, 300);
        repeat (d) tick();
        locked = 1'b1;
        run_len(2, 1'b0, LOCK_TO_READY + 50, n);
        check("lock_to_ready", 32'(n), 32'(LOCK_TO_READY));
        check("run_sys_rst", 32'(sys_rst), 32'd0);
        check("acq_no_clk_rst", 32'(crst_or), 32'd0);

        // Lock loss in RUN
        k = $urandom_range(5, 50);
        run_len(2, 1'b1, k, n);
        check("ready_holds_in_run", 32'(n), 32'(k));
        locked = 1'b0;
        run_len(1, 1'b0, 20, n);
        check("drop_to_sys_rst", 32'(n), 32'(DROP_TO_RST));
        check("drop_clk_rst_rises", 32'(clk_rst), 32'd1);
        check("drop_ready_falls", 32'(ready), 32'd0);
        run_len(0, 1'b1, RSTC + 50, n);
        check("hold_len_after_loss", 32'(n), 32'(RSTC));
`ifdef CLK_RESET_SEQ_STATUS_EN
        check("lock_lost_set", 32'(lock_lost), 32'd1);
        check("retry_unchanged_loss", 32'(retry_count), 32'd1);
`endif

        // Lock glitch at settle count 30 forces a full re-settle
        crst_or = 1'b0;
        d = $urandom_range(5, 100);
        repeat (d) tick();
        locked = 1'b1;
        repeat (SYNC + 1 + 30) tick();
        check("settle_not_ready", 32'(ready), 32'd0);
        locked = 1'b0;
        len = $urandom_range(1, 6);
        repeat (len) tick();
        locked = 1'b1;
        run_len(2, 1'b0, LOCK_TO_READY + 50, n);
        check("resettle_full", 32'(n), 32'(LOCK_TO_READY));
        check("glitch_no_clk_rst", 32'(crst_or), 32'd0);

        // Lock arriving on the final timeout cycle wins over the retry
        locked = 1'b0;
        run_len(1, 1'b0, 20, n);
        check("drop2_to_sys_rst", 32'(n), 32'(DROP_TO_RST));
        run_len(0, 1'b1, RSTC + 50, n);
        check("hold_len_drop2", 32'(n), 32'(RSTC));
        repeat (TO - SYNC - 1) tick();
        locked = 1'b1;
        repeat (SYNC + 1) tick();
        check("tie_lock_wins", 32'(clk_rst), 32'd0);
        run_len(2, 1'b0, SET + 50, n);
        check("tie_settle_len", 32'(n), 32'(SET));
`ifdef CLK_RESET_SEQ_STATUS_EN
        check("retry_unchanged_tie", 32'(retry_count), 32'd1);
`endif

        // rst asserted mid-WAIT_LOCK
        locked = 1'b0;
        run_len(1, 1'b0, 20, n);
        check("drop3_to_sys_rst", 32'(n), 32'(DROP_TO_RST));
        run_len(0, 1'b1, RSTC + 50, n);
        check("hold_len_drop3", 32'(n), 32'(RSTC));
        w = $urandom_range(1900, 2100);
        repeat (w) tick();
        check("mid_wait_clk_rst_low", 32'(clk_rst), 32'd0);
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        run_len(0, 1'b1, RSTC + 50, n);
        check("hold_len_after_mid_rst", 32'(n), 32'(RSTC));

        // Repeated timeouts; retry count saturates at 2^RW-1
        for (int i = 1; i <= 5; i++) begin
            run_len(0, 1'b0, TO + 50, n);
            check("retry_wait_len", 32'(n), 32'(TO));
            exp_retry = (i < (2 ** RW) - 1) ? i : (2 ** RW) - 1;
`ifdef CLK_RESET_SEQ_STATUS_EN
            check("retry_sat", 32'(retry_count), 32'(exp_retry));
`endif
            run_len(0, 1'b1, RSTC + 50, n);
            check("retry_hold_len", 32'(n), 32'(RSTC));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
